// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_if
//  Description : Source-side handshake and serial-line bundle for uart_tx.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic [5:0]            Prescale;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data, data_valid, par_en, par_typ, Prescale,
        input  tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ, Prescale,
        output tx_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter: start, DATA_WIDTH bits LSB first, optional
//                parity, stop. Define UART_TX_STOP2_EN for two stop bits.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic  clk,
    input  wire logic  rst,
    uart_tx_if.slave   bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    localparam logic [BW-1:0] c_LAST_BIT = BW'(DATA_WIDTH - 1);

    logic [2:0]            r_state;
    logic [5:0]            r_cnt;
    logic [5:0]            r_ps;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_tx;
    logic                  r_busy;
`ifdef UART_TX_STOP2_EN
    logic                  r_stop2;
`endif

    logic                  w_bit_end;
    logic                  w_parity;
    logic [5:0]            w_ps_in;
    logic [DATA_WIDTH-1:0] w_shift_nxt;

    // Prescale values below 4 are clamped so every bit lasts at least 4 cycles
    assign w_ps_in     = (bus.Prescale < 6'd4) ? 6'd4 : bus.Prescale;
    assign w_bit_end   = (r_cnt == (r_ps - 6'd1));
    assign w_parity    = (^r_data) ^ r_par_typ;
    assign w_shift_nxt = r_shift >> 1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_ps      <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_STOP2_EN
            r_stop2   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.data_valid) begin
                        r_shift   <= bus.p_data;
                        r_data    <= bus.p_data;
                        r_par_en  <= bus.par_en;
                        r_par_typ <= bus.par_typ;
                        r_ps      <= w_ps_in;
                        r_cnt     <= '0;
                        r_bit     <= '0;
                        r_state   <= c_START;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                c_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= c_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == c_LAST_BIT) begin
                            if (r_par_en) begin
                                r_state <= c_PARITY;
                                r_tx    <= w_parity;
                            end else begin
                                r_state <= c_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= w_shift_nxt;
                            r_tx    <= w_shift_nxt[0];
                        end
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                c_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= c_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                c_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
`ifdef UART_TX_STOP2_EN
                        if (!r_stop2) begin
                            r_stop2 <= 1'b1;
                        end else begin
                            r_stop2 <= 1'b0;
                            r_state <= c_IDLE;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_out = r_tx;
    assign bus.busy   = r_busy;
endmodule
`default_nettype wire
